pipe_stage_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 43 ++++
 rtl/pipe_slot.sv | 34 +++
 rtl/pipe_stage_skid_reg.sv | 172 +++++++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state encoding, bubble
// default and the EX/MEM payload layout that parents pack into data_in.
package pipe_pkg;

  // Occupancy states of a stage register
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] HALF  = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  // Control encoding of an empty slot (NOP)
  localparam int unsigned CTRL_BUBBLE_DEF = 1;

  // EX/MEM payload layout, LSB first
  localparam int EXMEM_ALU_LSB   = 0;
  localparam int EXMEM_ALU_W     = 32;
  localparam int EXMEM_STORE_LSB = EXMEM_ALU_LSB + EXMEM_ALU_W;
  localparam int EXMEM_STORE_W   = 32;
  localparam int EXMEM_PC_LSB    = EXMEM_STORE_LSB + EXMEM_STORE_W;
  localparam int EXMEM_PC_W      = 32;
  localparam int EXMEM_RD_LSB    = EXMEM_PC_LSB + EXMEM_PC_W;
  localparam int EXMEM_RD_W      = 5;
  localparam int EXMEM_EXC_LSB   = EXMEM_RD_LSB + EXMEM_RD_W;
  localparam int EXMEM_EXC_W     = 8;
  localparam int EXMEM_DATA_W    = EXMEM_EXC_LSB + EXMEM_EXC_W;

  typedef struct packed {
    logic [EXMEM_EXC_W-1:0]   exc;
    logic [EXMEM_RD_W-1:0]    rd;
    logic [EXMEM_PC_W-1:0]    pc;
    logic [EXMEM_STORE_W-1:0] store;
    logic [EXMEM_ALU_W-1:0]   alu;
  } exmem_payload_t;

  // Number of valid entries held in a given state
  function automatic logic [1:0] held_count(input logic [1:0] state);
    case (state)
      HALF:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One ctrl+data register of a stage; clear forces the bubble value and
// takes priority over load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_q
);

  // Slot contents: bubble on reset/clear, new entry on load, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= CTRL_BUBBLE;
      data_q <= '0;
    end else if (clear) begin
      ctrl_q <= CTRL_BUBBLE;
      data_q <= '0;
    end else if (load) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush to
// bubble, optional 2-entry skid buffer and a saturating flush-drop counter.
//
//   state | meaning
//   ------+----------------------------------------------
//   EMPTY | no entry held, head shows the bubble
//   HALF  | head slot holds the only entry
//   FULL  | head and skid both hold entries (skid only)
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF),
  parameter int                SKID_EN     = 1,
  parameter int                CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              accept;
  logic              pop;
  logic              head_load;
  logic              head_clear;
  logic              skid_load;
  logic              skid_clear;
  logic [CTRL_W-1:0] head_ctrl_d;
  logic [DATA_W-1:0] head_data_d;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [1:0]        drop_n;
  logic [CNT_W:0]    drop_sum;

  assign out_valid = (state != EMPTY);

  // With the skid buffer in_ready depends only on state, breaking the
  // combinational path from out_ready back upstream.
  if (SKID_EN != 0) begin : g_rdy_skid
    assign in_ready = (state != FULL);
  end else begin : g_rdy_direct
    assign in_ready = !out_valid || out_ready;
  end

  // A flush cycle never accepts, but in_ready still reflects the old state
  assign accept = in_valid && in_ready && !flush;
  assign pop    = out_valid && out_ready;

  // Head refills from the skid entry when draining FULL, else from upstream
  assign head_ctrl_d = (state == FULL) ? skid_ctrl : ctrl_in;
  assign head_data_d = (state == FULL) ? skid_data : data_in;

  // Next state, slot enables and number of entries a flush throws away
  always_comb begin
    state_nxt  = state;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    drop_n     = 2'd0;
    if (flush) begin
      state_nxt  = EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
      drop_n     = held_count(state) - {1'b0, pop};
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_load = 1'b1;
            state_nxt = HALF;
          end
        end
        HALF: begin
          if (accept && pop) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_nxt = FULL;
          end else if (pop) begin
            head_clear = 1'b1;
            state_nxt  = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_load  = 1'b1;
            skid_clear = 1'b1;
            state_nxt  = HALF;
          end
        end
        default: begin
          state_nxt  = EMPTY;
          head_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(drop_n);

  // Flush-drop counter, clamped at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (drop_sum[CNT_W]) begin
      drop_cnt <= '1;
    end else begin
      drop_cnt <= drop_sum[CNT_W-1:0];
    end
  end

  pipe_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_head (
    .clk    (clk),
    .reset  (reset),
    .load   (head_load),
    .clear  (head_clear),
    .ctrl_d (head_ctrl_d),
    .data_d (head_data_d),
    .ctrl_q (ctrl_out),
    .data_q (data_out)
  );

  if (SKID_EN != 0) begin : g_skid
    pipe_slot #(
      .DATA_W      (DATA_W),
      .CTRL_W      (CTRL_W),
      .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load),
      .clear  (skid_clear),
      .ctrl_d (ctrl_in),
      .data_d (data_in),
      .ctrl_q (skid_ctrl),
      .data_q (skid_data)
    );
  end else begin : g_no_skid
    logic unused_skid;
    assign skid_ctrl   = CTRL_BUBBLE;
    assign skid_data   = '0;
    assign unused_skid = skid_load ^ skid_clear;
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: three instances (skid, no-skid, skid with a
// 2-bit drop counter), directed scenarios plus random traffic against a
// queue-based reference model.
module tb_pipe_stage_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        flush     [3];
  logic [7:0]  ctrl_in   [3];
  logic [7:0]  ctrl_out  [3];
  logic [31:0] data_in   [3];
  logic [31:0] data_out  [3];
  logic [7:0]  drop_a;
  logic [7:0]  drop_b;
  logic [1:0]  drop_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.SKID_EN(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .ctrl_in(ctrl_in[0]), .data_in(data_in[0]), .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .ctrl_out(ctrl_out[0]),
    .data_out(data_out[0]), .drop_cnt(drop_a));

  pipe_stage_skid_reg #(.SKID_EN(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .ctrl_in(ctrl_in[1]), .data_in(data_in[1]), .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .ctrl_out(ctrl_out[1]),
    .data_out(data_out[1]), .drop_cnt(drop_b));

  pipe_stage_skid_reg #(.SKID_EN(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .ctrl_in(ctrl_in[2]), .data_in(data_in[2]), .flush(flush[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .ctrl_out(ctrl_out[2]),
    .data_out(data_out[2]), .drop_cnt(drop_c));

  function automatic int get_drop(input int d);
    if (d == 0) return int'(drop_a);
    if (d == 1) return int'(drop_b);
    return int'(drop_c);
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      flush[d]     = 1'b0;
      ctrl_in[d]   = 8'h00;
      data_in[d]   = 32'h0;
    end
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b1; ctrl_in[d] = 8'hAA; data_in[d] = 32'hFFFF_FFFF; out_ready[d] = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++; if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_valid d=%0d got %b exp 0", d, out_valid[d]); end
      checks++; if (ctrl_out[d] !== 8'h01) begin errors++; $display("FAIL reset_ctrl d=%0d got %h exp 01", d, ctrl_out[d]); end
      checks++; if (data_out[d] !== 32'h0) begin errors++; $display("FAIL reset_data d=%0d got %h exp 0", d, data_out[d]); end
      checks++; if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_ready d=%0d got %b exp 1", d, in_ready[d]); end
      checks++; if (get_drop(d) != 0) begin errors++; $display("FAIL reset_drop d=%0d got %0d exp 0", d, get_drop(d)); end
    end
    rst_n = 1'b1;
    idle_all();
    #1;
  endtask

  task automatic test_fill;
    in_valid[0] = 1'b1; ctrl_in[0] = 8'h5A; data_in[0] = 32'hDEAD_BEEF; out_ready[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL fill_valid got %b exp 1", out_valid[0]); end
    checks++; if (ctrl_out[0] !== 8'h5A) begin errors++; $display("FAIL fill_ctrl got %h exp 5a", ctrl_out[0]); end
    checks++; if (data_out[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fill_data got %h exp deadbeef", data_out[0]); end
    tick();
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL fill_drain_valid got %b exp 0", out_valid[0]); end
    checks++; if (ctrl_out[0] !== 8'h01) begin errors++; $display("FAIL fill_drain_ctrl got %h exp 01", ctrl_out[0]); end
    out_ready[0] = 1'b0;
  endtask

  task automatic test_skid_stall;
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; ctrl_in[0] = 8'h11; data_in[0] = 32'd1;
    #1;
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL skid_rdy_a got %b exp 1", in_ready[0]); end
    tick();
    ctrl_in[0] = 8'h12; data_in[0] = 32'd2;
    #1;
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL skid_rdy_b got %b exp 1", in_ready[0]); end
    tick();
    ctrl_in[0] = 8'h13; data_in[0] = 32'd3;
    #1;
    checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL skid_full_rdy got %b exp 0", in_ready[0]); end
    checks++; if (data_out[0] !== 32'd1) begin errors++; $display("FAIL skid_head got %0d exp 1", data_out[0]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (data_out[0] !== 32'd1 || ctrl_out[0] !== 8'h11) begin errors++; $display("FAIL skid_stall_stable got %h/%0d exp 11/1", ctrl_out[0], data_out[0]); end
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL skid_stall_rdy got %b exp 0", in_ready[0]); end
    end
    out_ready[0] = 1'b1;
    tick();
    checks++; if (data_out[0] !== 32'd2 || ctrl_out[0] !== 8'h12) begin errors++; $display("FAIL skid_out2 got %h/%0d exp 12/2", ctrl_out[0], data_out[0]); end
    tick();
    in_valid[0] = 1'b0;
    checks++; if (data_out[0] !== 32'd3 || out_valid[0] !== 1'b1) begin errors++; $display("FAIL skid_out3 got %0d valid %b exp 3 valid 1", data_out[0], out_valid[0]); end
    tick();
    checks++; if (out_valid[0] !== 1'b0 || ctrl_out[0] !== 8'h01) begin errors++; $display("FAIL skid_empty got valid %b ctrl %h exp 0/01", out_valid[0], ctrl_out[0]); end
    out_ready[0] = 1'b0;
  endtask

  task automatic test_flush_full;
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; ctrl_in[0] = 8'h21; data_in[0] = 32'd1;
    tick();
    ctrl_in[0] = 8'h22; data_in[0] = 32'd2;
    tick();
    flush[0] = 1'b1; ctrl_in[0] = 8'h29; data_in[0] = 32'd9;
    #1;
    checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL flush_full_rdy got %b exp 0", in_ready[0]); end
    tick();
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_full_valid got %b exp 0", out_valid[0]); end
    checks++; if (ctrl_out[0] !== 8'h01 || data_out[0] !== 32'h0) begin errors++; $display("FAIL flush_full_bubble got %h/%h exp 01/0", ctrl_out[0], data_out[0]); end
    checks++; if (get_drop(0) != 2) begin errors++; $display("FAIL flush_full_drop got %0d exp 2", get_drop(0)); end
    out_ready[0] = 1'b1;
    tick();
    tick();
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_full_no9 got valid %b data %0d exp 0", out_valid[0], data_out[0]); end
    out_ready[0] = 1'b0;
  endtask

  task automatic test_flush_pop;
    in_valid[0] = 1'b1; ctrl_in[0] = 8'h35; data_in[0] = 32'd5;
    tick();
    in_valid[0] = 1'b0;
    checks++; if (out_valid[0] !== 1'b1 || data_out[0] !== 32'd5) begin errors++; $display("FAIL flush_pop_head got %b/%0d exp 1/5", out_valid[0], data_out[0]); end
    out_ready[0] = 1'b1; flush[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0; flush[0] = 1'b0;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_pop_valid got %b exp 0", out_valid[0]); end
    checks++; if (get_drop(0) != 2) begin errors++; $display("FAIL flush_pop_drop got %0d exp 2", get_drop(0)); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL flush_pop_rdy got %b exp 1", in_ready[0]); end
  endtask

  task automatic test_saturation;
    out_ready[2] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid[2] = 1'b1; data_in[2] = 32'(k);
      tick();
      in_valid[2] = 1'b0; flush[2] = 1'b1;
      tick();
      flush[2] = 1'b0;
      checks++; if (get_drop(2) != k) begin errors++; $display("FAIL sat_single k=%0d got %0d exp %0d", k, get_drop(2), k); end
    end
    in_valid[2] = 1'b1; data_in[2] = 32'd7;
    tick();
    data_in[2] = 32'd8;
    tick();
    in_valid[2] = 1'b0; flush[2] = 1'b1;
    tick();
    flush[2] = 1'b0;
    checks++; if (get_drop(2) != 3) begin errors++; $display("FAIL sat_double got %0d exp 3", get_drop(2)); end
    checks++; if (out_valid[2] !== 1'b0) begin errors++; $display("FAIL sat_empty got %b exp 0", out_valid[2]); end
  endtask

  task automatic test_stream_noskid;
    out_ready[1] = 1'b1; in_valid[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ctrl_in[1] = 8'h80 | 8'(i); data_in[1] = 32'(i);
      #1;
      checks++; if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL stream_rdy i=%0d got %b exp 1", i, in_ready[1]); end
      tick();
      checks++; if (out_valid[1] !== 1'b1 || data_out[1] !== 32'(i)) begin errors++; $display("FAIL stream_out i=%0d got %b/%0d exp 1/%0d", i, out_valid[1], data_out[1], i); end
    end
  endtask

  task automatic test_async_reset;
    out_ready[1] = 1'b1; in_valid[1] = 1'b1; ctrl_in[1] = 8'hC3; data_in[1] = 32'hA5;
    tick();
    checks++; if (out_valid[1] !== 1'b1 || data_out[1] !== 32'hA5) begin errors++; $display("FAIL areset_pre got %b/%h exp 1/a5", out_valid[1], data_out[1]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", out_valid[1]); end
    checks++; if (ctrl_out[1] !== 8'h01 || data_out[1] !== 32'h0) begin errors++; $display("FAIL areset_bubble got %h/%h exp 01/0", ctrl_out[1], data_out[1]); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_all();
  endtask

  task automatic test_random(input int d, input int n);
    logic [39:0] q[$];
    logic [39:0] head;
    int          drop;
    int          maxd;
    bit          skid;
    logic        exp_ready;
    bit          pop;
    bit          acc;
    skid = (d != 1);
    maxd = (d == 2) ? 3 : 255;
    drop = 0;
    idle_all();
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      in_valid[d]  = ($urandom_range(0, 3) != 0);
      out_ready[d] = ($urandom_range(0, 2) != 0);
      flush[d]     = ($urandom_range(0, 11) == 0);
      ctrl_in[d]   = 8'($urandom);
      data_in[d]   = $urandom;
      #1;
      head = (q.size() > 0) ? q[0] : {8'h01, 32'h0};
      exp_ready = skid ? (q.size() < 2) : (q.size() == 0 || out_ready[d]);
      checks++; if (in_ready[d] !== exp_ready) begin errors++; $display("FAIL rand_rdy d=%0d cyc=%0d got %b exp %b", d, i, in_ready[d], exp_ready); end
      checks++; if (out_valid[d] !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid d=%0d cyc=%0d got %b exp %b", d, i, out_valid[d], q.size() > 0); end
      checks++; if (ctrl_out[d] !== head[39:32]) begin errors++; $display("FAIL rand_ctrl d=%0d cyc=%0d got %h exp %h", d, i, ctrl_out[d], head[39:32]); end
      checks++; if (data_out[d] !== head[31:0]) begin errors++; $display("FAIL rand_data d=%0d cyc=%0d got %h exp %h", d, i, data_out[d], head[31:0]); end
      checks++; if (get_drop(d) != drop) begin errors++; $display("FAIL rand_drop d=%0d cyc=%0d got %0d exp %0d", d, i, get_drop(d), drop); end
      pop = (q.size() > 0) && out_ready[d];
      acc = in_valid[d] && exp_ready && !flush[d];
      if (pop) void'(q.pop_front());
      if (flush[d]) begin
        drop += q.size();
        if (drop > maxd) drop = maxd;
        q.delete();
      end else if (acc) begin
        q.push_back({ctrl_in[d], data_in[d]});
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    rst_n = 1'b0;
    test_reset();
    test_fill();
    test_skid_stall();
    test_flush_full();
    test_flush_pop();
    test_saturation();
    test_stream_noskid();
    test_async_reset();
    test_random(0, 400);
    test_random(1, 400);
    test_random(2, 400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
